// File: rtl/memory_cycle_bus_if.sv
// ---------------------------------------------------------------------------
// memory_cycle_bus_if
// Data-bus bundle between the MEM stage (master) and data memory (slave).
//   req    master->slave  access request
//   we     master->slave  1 = write, 0 = read
//   addr   master->slave  word-aligned byte address
//   wdata  master->slave  store data
//   ack    slave->master  access completes this cycle
//   rdata  slave->master  read data, valid with ack on reads
// ---------------------------------------------------------------------------
interface memory_cycle_bus_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, output we, output addr, output wdata,
                   input  ack, input  rdata);
   modport slave  (input  req, input  we, input  addr, input  wdata,
                   output ack, output rdata);
endinterface

// File: rtl/memory_cycle_bus.sv
// ---------------------------------------------------------------------------
// memory_cycle_bus
// MEM stage of a 5-stage RISC-V pipeline. Performs word loads/stores over a
// req/ack data bus with variable wait states, stalls the upstream pipeline
// while an access is outstanding, aborts accesses that exceed MAX_WAIT stall
// cycles, and owns the MEM/WB pipeline register.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   RegWriteM .. ALU_ResultM EX/MEM bundle (control, rd, pc+4, data, address)
//   dbus                     data bus (master side)
//   StallM                   freeze PC, IF/ID, ID/EX, EX/MEM
//   BusErrM                  sticky timeout / misaligned-access flag
//   RegWriteW .. ReadDataW   MEM/WB register outputs
// ---------------------------------------------------------------------------
module memory_cycle_bus #(
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteM,
   input  logic        MemWriteM,
   input  logic        ResultSrcM,
   input  logic [4:0]  RD_M,
   input  logic [31:0] PCPlus4M,
   input  logic [31:0] WriteDataM,
   input  logic [31:0] ALU_ResultM,
   memory_cycle_bus_if.master dbus,
   output logic        StallM,
   output logic        BusErrM,
   output logic        RegWriteW,
   output logic        ResultSrcW,
   output logic [4:0]  RD_W,
   output logic [31:0] PCPlus4W,
   output logic [31:0] ALU_ResultW,
   output logic [31:0] ReadDataW
);

   localparam int unsigned CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

   typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [CW-1:0]   wait_cnt_r;
   logic [CW-1:0]   wait_cnt_nxt_s;

   logic memop_s;
   logic misaligned_s;
   logic req_s;
   logic stall_s;
   logic retire_s;     // MEM/WB captures the M bundle this cycle
   logic complete_s;   // access finished with ack
   logic err_set_s;    // misaligned or timed out: kill the write-back

   assign memop_s      = MemWriteM | ResultSrcM;
   assign misaligned_s = memop_s & (ALU_ResultM[1:0] != 2'b00);

   // Upstream is frozen while waiting, so the M bundle itself holds the bus
   // fields stable; only req is qualified by the FSM.
   assign dbus.req   = req_s;
   assign dbus.we    = MemWriteM;
   assign dbus.addr  = ALU_ResultM;
   assign dbus.wdata = WriteDataM;
   assign StallM     = stall_s;

   // Next-state, bus request, stall and retire decode.
   always_comb begin
      state_nxt_s    = state_r;
      wait_cnt_nxt_s = wait_cnt_r;
      req_s          = 1'b0;
      stall_s        = 1'b0;
      retire_s       = 1'b0;
      complete_s     = 1'b0;
      err_set_s      = 1'b0;
      if (rst) begin
         state_nxt_s    = IDLE;
         wait_cnt_nxt_s = '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (misaligned_s) begin
                  retire_s  = 1'b1;
                  err_set_s = 1'b1;
               end else if (memop_s) begin
                  req_s = 1'b1;
                  if (dbus.ack) begin
                     retire_s   = 1'b1;
                     complete_s = 1'b1;
                  end else begin
                     stall_s        = 1'b1;
                     state_nxt_s    = WAIT;
                     wait_cnt_nxt_s = CW'(1);
                  end
               end else begin
                  retire_s = 1'b1;
               end
            end
            WAIT: begin
               if (wait_cnt_r == MAX_CNT) begin
                  // Abort cycle: request dropped, any ack this cycle ignored.
                  retire_s       = 1'b1;
                  err_set_s      = 1'b1;
                  state_nxt_s    = IDLE;
                  wait_cnt_nxt_s = '0;
               end else begin
                  req_s = 1'b1;
                  if (dbus.ack) begin
                     retire_s       = 1'b1;
                     complete_s     = 1'b1;
                     state_nxt_s    = IDLE;
                     wait_cnt_nxt_s = '0;
                  end else begin
                     stall_s        = 1'b1;
                     wait_cnt_nxt_s = wait_cnt_r + CW'(1);
                  end
               end
            end
            default: begin
               state_nxt_s    = IDLE;
               wait_cnt_nxt_s = '0;
            end
         endcase
      end
   end

   // FSM state and wait counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         wait_cnt_r <= '0;
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= wait_cnt_nxt_s;
      end
   end

   // Sticky bus-error flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         BusErrM <= 1'b0;
      end else if (err_set_s) begin
         BusErrM <= 1'b1;
      end else begin
         BusErrM <= BusErrM;
      end
   end

   // MEM/WB register: capture on retire, bubble while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         RegWriteW   <= 1'b0;
         ResultSrcW  <= 1'b0;
         RD_W        <= 5'd0;
         PCPlus4W    <= 32'h0;
         ALU_ResultW <= 32'h0;
         ReadDataW   <= 32'h0;
      end else if (retire_s) begin
         RegWriteW   <= RegWriteM & ~err_set_s;
         ResultSrcW  <= ResultSrcM;
         RD_W        <= RD_M;
         PCPlus4W    <= PCPlus4M;
         ALU_ResultW <= ALU_ResultM;
         ReadDataW   <= (complete_s & ~MemWriteM) ? dbus.rdata : 32'h0;
      end else begin
         RegWriteW   <= 1'b0;
         ResultSrcW  <= 1'b0;
         RD_W        <= 5'd0;
         PCPlus4W    <= 32'h0;
         ALU_ResultW <= 32'h0;
         ReadDataW   <= 32'h0;
      end
   end

endmodule

// File: tb/tb_memory_cycle_bus.sv
// ---------------------------------------------------------------------------
// tb_memory_cycle_bus
// Drives instructions one at a time into the MEM stage together with a bus
// responder whose ack latency is chosen per instruction. Expected bus, stall
// and write-back values come from a transaction-level model: an aligned memop
// with ack latency L stalls min(L, MAX_WAIT) cycles and times out when
// L >= MAX_WAIT.
// ---------------------------------------------------------------------------
module tb_memory_cycle_bus;
   localparam int MW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        RegWriteM, MemWriteM, ResultSrcM;
   logic [4:0]  RD_M;
   logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
   logic        StallM, BusErrM, RegWriteW, ResultSrcW;
   logic [4:0]  RD_W;
   logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

   int   n_chk = 0;
   int   n_bad = 0;
   logic model_err = 1'b0;

   memory_cycle_bus_if dbus ();

   memory_cycle_bus #(.MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
      .ALU_ResultM(ALU_ResultM), .dbus(dbus),
      .StallM(StallM), .BusErrM(BusErrM),
      .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
      .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   task automatic drive_idle();
      RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 1'b0; RD_M = 5'd0;
      PCPlus4M = 32'h0; WriteDataM = 32'h0; ALU_ResultM = 32'h0;
      dbus.ack = 1'b0; dbus.rdata = 32'h0;
   endtask

   // kind: 0 = ALU op, 1 = load, 2 = store. lat = cycles before ack.
   task automatic run_instr(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdv, input logic [4:0] rd, input logic regw,
                            input int lat);
      logic        memop, mis, tmo, ok;
      int          r;
      logic [31:0] pc;
      pc    = $urandom;
      memop = (kind != 0);
      mis   = memop && (addr[1:0] != 2'b00);
      ok    = memop && !mis;
      tmo   = ok && (lat >= MW);
      r     = ok ? ((lat < MW) ? lat : MW) : 0;
      for (int c = 0; c <= r; c++) begin
         @(negedge clk);
         if (c == 0) begin
            RegWriteM = regw; MemWriteM = (kind == 2); ResultSrcM = (kind == 1);
            RD_M = rd; PCPlus4M = pc; WriteDataM = wd; ALU_ResultM = addr;
         end
         dbus.ack   = (c == lat);
         dbus.rdata = (c == lat) ? rdv : $urandom;
         #1;
         check_eq("req", {31'b0, dbus.req}, {31'b0, (c < r) || (c == r && ok && !tmo)});
         check_eq("stall", {31'b0, StallM}, {31'b0, c < r});
         if (ok && !(tmo && c == r)) begin
            check_eq("addr", dbus.addr, addr);
            check_eq("we", {31'b0, dbus.we}, {31'b0, kind == 2});
            if (kind == 2) check_eq("wdata", dbus.wdata, wd);
         end
         @(posedge clk);
         #1;
         if (c < r) begin
            check_eq("bubble_regw", {31'b0, RegWriteW}, 32'h0);
            check_eq("bubble_rd", {27'b0, RD_W}, 32'h0);
         end else begin
            model_err = model_err | mis | tmo;
            check_eq("regw_w", {31'b0, RegWriteW}, {31'b0, regw && !mis && !tmo});
            check_eq("rsrc_w", {31'b0, ResultSrcW}, {31'b0, kind == 1});
            check_eq("rd_w", {27'b0, RD_W}, {27'b0, rd});
            check_eq("pc4_w", PCPlus4W, pc);
            check_eq("alu_w", ALU_ResultW, addr);
            check_eq("rdata_w", ReadDataW, (kind == 1 && ok && !tmo) ? rdv : 32'h0);
            check_eq("buserr", {31'b0, BusErrM}, {31'b0, model_err});
         end
      end
   endtask

   initial begin
      logic [31:0] a;
      int          k;
      rst = 1'b1;
      drive_idle();
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_regw", {31'b0, RegWriteW}, 32'h0);
      check_eq("rst_err", {31'b0, BusErrM}, 32'h0);
      check_eq("rst_req", {31'b0, dbus.req}, 32'h0);
      check_eq("rst_stall", {31'b0, StallM}, 32'h0);
      check_eq("rst_rdata", ReadDataW, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Directed scenarios.
      run_instr(1, 32'h100, 32'h0, 32'hDEADBEEF, 5'd5, 1'b1, 0);
      run_instr(2, 32'h200, 32'h12345678, 32'h0, 5'd0, 1'b0, 3);
      run_instr(1, 32'h300, 32'h0, 32'h0, 5'd9, 1'b1, 99);
      run_instr(0, 32'h5, 32'h0, 32'h0, 5'd7, 1'b1, 0);
      run_instr(1, 32'h104, 32'h0, 32'hA5A5A5A5, 5'd1, 1'b1, 0);
      run_instr(1, 32'h108, 32'h0, 32'h5A5A5A5A, 5'd2, 1'b1, 0);
      run_instr(1, 32'h102, 32'h0, 32'h11111111, 5'd3, 1'b1, 0);
      run_instr(2, 32'h204, 32'hCAFEF00D, 32'h0, 5'd0, 1'b0, MW);

      // Reset on the second WAIT cycle of a load that never acks.
      @(negedge clk);
      RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 1'b1; RD_M = 5'd4;
      PCPlus4M = 32'h44; ALU_ResultM = 32'h400; dbus.ack = 1'b0;
      #1;
      check_eq("pre_rst_stall", {31'b0, StallM}, 32'h1);
      check_eq("pre_rst_err", {31'b0, BusErrM}, {31'b0, model_err});
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("midrst_req", {31'b0, dbus.req}, 32'h0);
      check_eq("midrst_stall", {31'b0, StallM}, 32'h0);
      @(posedge clk);
      #1;
      model_err = 1'b0;
      check_eq("midrst_err", {31'b0, BusErrM}, 32'h0);
      check_eq("midrst_regw", {31'b0, RegWriteW}, 32'h0);
      check_eq("midrst_rd", {27'b0, RD_W}, 32'h0);
      check_eq("midrst_alu", ALU_ResultW, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive_idle();

      // Randomized traffic.
      for (int i = 0; i < 150; i++) begin
         a = $urandom;
         if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
         k = $urandom_range(0, 2);
         run_instr(k, a, $urandom, $urandom, 5'($urandom_range(0, 31)),
                   (k == 1) ? 1'b1 : (k == 2) ? 1'b0 : 1'($urandom_range(0, 1)),
                   $urandom_range(0, 6));
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
